// File: rtl/bmf_stream_decoder.sv
// Purpose: programmable K x M Boolean-basis decoder; OR of the basis rows selected by each streamed latent code.
// Latency: 2 cycles (S1 captures the code, S2 captures the decoded word); 1 word/cycle under continuous out_ready.
// Backpressure: out_valid && !out_ready holds S2, S1 fills behind it, then in_ready drops. Optional macro: BMF_XOR_SEMIRING_EN.
module bmf_stream_decoder #(
  parameter int K     = 4,
  parameter int M     = 5,
  parameter int CNT_W = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 cfg_we,
  input  logic [$clog2(K)-1:0] cfg_row,
  input  logic [M-1:0]         cfg_data,
  input  logic                 cfg_commit,
  input  logic                 cfg_reopen,
  output logic                 cfg_err,
`ifdef BMF_XOR_SEMIRING_EN
  input  logic [M-1:0]         col_xor,
`endif
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [K-1:0]         in_code,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [M-1:0]         out_data,
  output logic [1:0]           state,
  output logic [CNT_W-1:0]     res_count
);

  localparam int RW = $clog2(K);
  localparam logic [RW:0] K_LIM = (RW + 1)'(K);

  typedef enum logic [1:0] {
    ST_CFG   = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [M-1:0]     row_q [K];
  logic [M-1:0]     row_d [K];
  logic [K-1:0]     mask_q, mask_d;
  logic             cfg_err_q, cfg_err_d;
  logic             s1_vld_q, s1_vld_d;
  logic [K-1:0]     s1_code_q, s1_code_d;
  logic             s2_vld_q, s2_vld_d;
  logic [M-1:0]     s2_data_q, s2_data_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
`ifdef BMF_XOR_SEMIRING_EN
  logic [M-1:0]     mode_q, mode_d;
`endif

  logic             row_ok;
  logic [K-1:0]     wr_bit;
  logic             commit_ok;
  logic             s2_adv;
  logic             s1_adv;
  logic             in_fire;
  logic [M-1:0]     dec_or;
  logic [M-1:0]     dec_xor;
  logic [M-1:0]     dec;

  // S2 moves whenever it is empty or its word is being taken; S1 follows S2.
  assign s2_adv   = !s2_vld_q || out_ready;
  assign s1_adv   = s2_adv;
  assign in_ready = (state_q == ST_RUN) && !cfg_reopen && (!s1_vld_q || s1_adv);
  assign in_fire  = in_valid && in_ready;

  assign out_valid = s2_vld_q;
  assign out_data  = s2_data_q;
  assign cfg_err   = cfg_err_q;
  assign state     = state_q;
  assign res_count = cnt_q;

  // Decode the code held in S1 against the basis matrix (OR and XOR reductions).
  always_comb begin
    dec_or  = '0;
    dec_xor = '0;
    for (int r = 0; r < K; r++) begin
      if (s1_code_q[r]) begin
        dec_or  = dec_or | row_q[r];
        dec_xor = dec_xor ^ row_q[r];
      end
    end
`ifdef BMF_XOR_SEMIRING_EN
    dec = (dec_xor & mode_q) | (dec_or & ~mode_q);
`else
    dec = dec_or;
`endif
  end

  // Row index check and one-hot mask bit for the addressed row.
  always_comb begin
    row_ok = ({1'b0, cfg_row} < K_LIM);
    wr_bit = '0;
    if (row_ok) begin
      wr_bit[cfg_row] = 1'b1;
    end
  end

  // Mode FSM and basis register file; the matrix only changes in CFG.
  always_comb begin
    state_d   = state_q;
    row_d     = row_q;
    mask_d    = mask_q;
    cfg_err_d = 1'b0;
    commit_ok = 1'b0;
    case (state_q)
      ST_CFG: begin
        if (cfg_we) begin
          if (row_ok) begin
            row_d[cfg_row] = cfg_data;
            mask_d         = mask_q | wr_bit;
          end else begin
            cfg_err_d = 1'b1;
          end
        end
        // Commit sees a same-cycle write through mask_d.
        if (cfg_commit) begin
          if (&mask_d) begin
            state_d   = ST_RUN;
            commit_ok = 1'b1;
          end else begin
            cfg_err_d = 1'b1;
          end
        end
      end
      ST_RUN: begin
        if (cfg_we) begin
          cfg_err_d = 1'b1;
        end
        if (cfg_reopen) begin
          state_d = ST_DRAIN;
        end
      end
      ST_DRAIN: begin
        if (cfg_we) begin
          cfg_err_d = 1'b1;
        end
        if (!s1_vld_q && !s2_vld_q) begin
          state_d = ST_CFG;
        end
      end
      default: state_d = ST_CFG;
    endcase
  end

`ifdef BMF_XOR_SEMIRING_EN
  // Column combine mode is latched only when a commit is accepted.
  always_comb begin
    mode_d = mode_q;
    if (commit_ok) begin
      mode_d = col_xor;
    end
  end
`endif

  // Two-stage pipeline and result counter.
  always_comb begin
    s1_vld_d  = s1_vld_q;
    s1_code_d = s1_code_q;
    s2_vld_d  = s2_vld_q;
    s2_data_d = s2_data_q;
    cnt_d     = cnt_q;
    if (!s1_vld_q || s1_adv) begin
      s1_vld_d = in_fire;
      if (in_fire) begin
        s1_code_d = in_code;
      end
    end
    if (s2_adv) begin
      s2_vld_d = s1_vld_q;
      if (s1_vld_q) begin
        s2_data_d = dec;
      end
    end
    if (s2_vld_q && out_ready) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  // State registers with synchronous reset; reset discards in-flight words and the matrix.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= ST_CFG;
      for (int r = 0; r < K; r++) begin
        row_q[r] <= '0;
      end
      mask_q    <= '0;
      cfg_err_q <= 1'b0;
      s1_vld_q  <= 1'b0;
      s1_code_q <= '0;
      s2_vld_q  <= 1'b0;
      s2_data_q <= '0;
      cnt_q     <= '0;
`ifdef BMF_XOR_SEMIRING_EN
      mode_q    <= '0;
`endif
    end else begin
      state_q   <= state_d;
      row_q     <= row_d;
      mask_q    <= mask_d;
      cfg_err_q <= cfg_err_d;
      s1_vld_q  <= s1_vld_d;
      s1_code_q <= s1_code_d;
      s2_vld_q  <= s2_vld_d;
      s2_data_q <= s2_data_d;
      cnt_q     <= cnt_d;
`ifdef BMF_XOR_SEMIRING_EN
      mode_q    <= mode_d;
`endif
    end
  end

endmodule

// File: tb/tb_bmf_stream_decoder.sv
// Bench for bmf_stream_decoder: random and directed streams against a queue-based reference model.
module tb_bmf_stream_decoder;

  localparam int K     = 4;
  localparam int M     = 5;
  localparam int CNT_W = 4;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             cfg_we = 1'b0;
  logic [1:0]       cfg_row = '0;
  logic [M-1:0]     cfg_data = '0;
  logic             cfg_commit = 1'b0;
  logic             cfg_reopen = 1'b0;
  logic             cfg_err;
`ifdef BMF_XOR_SEMIRING_EN
  logic [M-1:0]     col_xor = '0;
`endif
  logic             in_valid = 1'b0;
  logic             in_ready;
  logic [K-1:0]     in_code = '0;
  logic             out_valid;
  logic             out_ready = 1'b0;
  logic [M-1:0]     out_data;
  logic [1:0]       state;
  logic [CNT_W-1:0] res_count;

  bmf_stream_decoder #(.K(K), .M(M), .CNT_W(CNT_W)) dut (
    .clk        (clk),
    .rst        (rst),
    .cfg_we     (cfg_we),
    .cfg_row    (cfg_row),
    .cfg_data   (cfg_data),
    .cfg_commit (cfg_commit),
    .cfg_reopen (cfg_reopen),
    .cfg_err    (cfg_err),
`ifdef BMF_XOR_SEMIRING_EN
    .col_xor    (col_xor),
`endif
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_code    (in_code),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_data   (out_data),
    .state      (state),
    .res_count  (res_count)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Reference model: matrix, mode, state, and the words accepted but not yet delivered.
  logic [M-1:0] m_row [K];
  logic [K-1:0] m_mask;
  logic [M-1:0] m_mode;
  logic [1:0]   m_state;
  int           m_count;
  logic [K-1:0] code_q [$];
  int           acc_q [$];
  logic [M-1:0] got_q [$];
  bit           last_acc;
  int           vectors = 0;
  int           errors  = 0;

  // Column j: count selected rows with bit j set; OR = any, XOR = odd parity.
  function automatic logic [M-1:0] ref_dec(input logic [K-1:0] c);
    logic [M-1:0] o;
    o = '0;
    for (int j = 0; j < M; j++) begin
      int ones;
      ones = 0;
      for (int r = 0; r < K; r++) begin
        if (c[r] && m_row[r][j]) ones++;
      end
      o[j] = m_mode[j] ? ((ones % 2) == 1) : (ones > 0);
    end
    return o;
  endfunction

  task automatic do_reset();
    rst = 1'b1; cfg_we = 0; cfg_commit = 0; cfg_reopen = 0; in_valid = 0; out_ready = 0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    for (int r = 0; r < K; r++) m_row[r] = '0;
    m_mask = '0; m_mode = '0; m_state = 2'd0; m_count = 0;
    code_q.delete(); acc_q.delete();
  endtask

  // One streaming cycle: drive, compare against the model, advance one clock, update the model.
  task automatic step(input logic iv, input logic [K-1:0] code, input logic ordy, input logic reopen);
    logic exp_ir, exp_ov, dlv;
    int   occ;
    in_valid = iv; in_code = code; out_ready = ordy; cfg_reopen = reopen;
    #1;
    occ    = code_q.size();
    exp_ir = (m_state == 2'd1) && !reopen && (occ < 2 || ordy);
    exp_ov = (occ > 0) && (acc_q[0] < cyc);
    vectors++;
    if (state !== m_state) begin errors++; $display("FAIL step_state: got %0d exp %0d @%0d", state, m_state, cyc); end
    vectors++;
    if (in_ready !== exp_ir) begin errors++; $display("FAIL step_in_ready: got %b exp %b @%0d", in_ready, exp_ir, cyc); end
    vectors++;
    if (out_valid !== exp_ov) begin errors++; $display("FAIL step_out_valid: got %b exp %b @%0d", out_valid, exp_ov, cyc); end
    vectors++;
    if (res_count !== CNT_W'(m_count)) begin errors++; $display("FAIL step_res_count: got %0d exp %0d @%0d", res_count, m_count, cyc); end
    if (exp_ov) begin
      vectors++;
      if (out_data !== ref_dec(code_q[0])) begin
        errors++; $display("FAIL step_out_data: got %b exp %b @%0d", out_data, ref_dec(code_q[0]), cyc);
      end
    end
    last_acc = iv && exp_ir;
    dlv      = exp_ov && ordy;
    if (dlv) got_q.push_back(out_data);
    @(negedge clk);
    if (dlv) begin
      void'(code_q.pop_front()); void'(acc_q.pop_front());
      m_count = (m_count + 1) % (1 << CNT_W);
    end
    if (last_acc) begin code_q.push_back(code); acc_q.push_back(cyc); end
    if (m_state == 2'd1 && reopen) m_state = 2'd2;
    else if (m_state == 2'd2 && occ == 0) m_state = 2'd0;
  endtask

  // One config cycle with no stream traffic; checks the error pulse and resulting state.
  task automatic cfg_op(input logic we, input logic [1:0] row, input logic [M-1:0] data, input logic commit);
    logic       exp_err;
    logic [1:0] nxt;
    in_valid = 0; out_ready = 0; cfg_reopen = 0;
    cfg_we = we; cfg_row = row; cfg_data = data; cfg_commit = commit;
    exp_err = 1'b0; nxt = m_state;
    if (m_state == 2'd0) begin
      if (we) begin m_row[row] = data; m_mask[row] = 1'b1; end
      if (commit) begin
        if (&m_mask) begin
          nxt = 2'd1;
`ifdef BMF_XOR_SEMIRING_EN
          m_mode = col_xor;
`endif
        end else exp_err = 1'b1;
      end
    end else begin
      if (we) exp_err = 1'b1;
      if (m_state == 2'd2 && code_q.size() == 0) nxt = 2'd0;
    end
    @(negedge clk);
    cfg_we = 0; cfg_commit = 0;
    m_state = nxt;
    vectors++;
    if (cfg_err !== exp_err) begin errors++; $display("FAIL cfg_err: got %b exp %b @%0d", cfg_err, exp_err, cyc); end
    vectors++;
    if (state !== m_state) begin errors++; $display("FAIL cfg_state: got %0d exp %0d @%0d", state, m_state, cyc); end
  endtask

  task automatic drain_to_cfg();
    for (int t = 0; t < 20 && m_state != 2'd0; t++) step(0, '0, 1, (m_state == 2'd1));
    vectors++;
    if (state !== 2'd0) begin errors++; $display("FAIL drain_timeout: state %0d exp 0", state); end
  endtask

  task automatic test_reset();
    do_reset();
    vectors++; if (state !== 2'd0) begin errors++; $display("FAIL rst_state: got %0d exp 0", state); end
    vectors++; if (out_valid !== 1'b0) begin errors++; $display("FAIL rst_out_valid: got %b exp 0", out_valid); end
    vectors++; if (out_data !== '0) begin errors++; $display("FAIL rst_out_data: got %b exp 0", out_data); end
    vectors++; if (in_ready !== 1'b0) begin errors++; $display("FAIL rst_in_ready: got %b exp 0", in_ready); end
    vectors++; if (cfg_err !== 1'b0) begin errors++; $display("FAIL rst_cfg_err: got %b exp 0", cfg_err); end
    vectors++; if (res_count !== '0) begin errors++; $display("FAIL rst_res_count: got %0d exp 0", res_count); end
  endtask

  task automatic test_config_check();
    step(0, '0, 0, 1);                       // reopen in CFG does nothing
    cfg_op(1, 2'd0, 5'b00010, 0);
    cfg_op(1, 2'd1, 5'b00101, 0);
    cfg_op(1, 2'd2, 5'b01001, 0);
    cfg_op(0, 2'd0, '0, 1);                  // incomplete mask: rejected
    vectors++; if (in_ready !== 1'b0) begin errors++; $display("FAIL cfg_incomplete_in_ready: got %b exp 0", in_ready); end
    @(negedge clk);
    vectors++; if (cfg_err !== 1'b0) begin errors++; $display("FAIL cfg_err_one_cycle: got %b exp 0", cfg_err); end
    cfg_op(1, 2'd3, 5'b10001, 1);            // same-cycle write + commit
    vectors++; if (state !== 2'd1) begin errors++; $display("FAIL cfg_commit_state: got %0d exp 1", state); end
    vectors++; if (in_ready !== 1'b1) begin errors++; $display("FAIL cfg_commit_in_ready: got %b exp 1", in_ready); end
    cfg_op(1, 2'd3, 5'b11111, 0);            // write in RUN: rejected, row kept
  endtask

  task automatic test_or_decode();
    step(1, 4'b0110, 1, 0);
    step(0, '0, 1, 0);
    vectors++; if (out_valid !== 1'b1 || out_data !== 5'b01101) begin errors++; $display("FAIL or_0110: got v=%b %b exp v=1 01101", out_valid, out_data); end
    step(1, 4'b1110, 1, 0);
    step(0, '0, 1, 0);
    vectors++; if (out_valid !== 1'b1 || out_data !== 5'b11101) begin errors++; $display("FAIL or_1110: got v=%b %b exp v=1 11101", out_valid, out_data); end
    step(0, '0, 1, 0);
    vectors++; if (res_count !== 4'd2) begin errors++; $display("FAIL or_res_count: got %0d exp 2", res_count); end
    step(1, 4'b1000, 1, 0);                  // row 3 must still be 10001
    step(0, '0, 1, 0);
    vectors++; if (out_data !== 5'b10001) begin errors++; $display("FAIL run_write_ignored: got %b exp 10001", out_data); end
    step(1, 4'b0000, 1, 0);
    step(0, '0, 1, 0);
    vectors++; if (out_valid !== 1'b1 || out_data !== 5'b00000) begin errors++; $display("FAIL zero_code: got v=%b %b exp v=1 00000", out_valid, out_data); end
    step(0, '0, 1, 0);
  endtask

  task automatic test_backpressure();
    logic [K-1:0] codes [4];
    logic [M-1:0] exp_bp [4];
    int idx;
    codes  = '{4'b0001, 4'b0010, 4'b0100, 4'b1000};
    exp_bp = '{5'b00010, 5'b00101, 5'b01001, 5'b10001};
    got_q.delete();
    idx = 0;
    for (int t = 0; t < 40 && (idx < 4 || code_q.size() > 0); t++) begin
      step(idx < 4, (idx < 4) ? codes[idx] : 4'd0, t >= 3, 0);
      if (last_acc) idx++;
      if (t == 1 || t == 2) begin
        vectors++; if (out_data !== 5'b00010) begin errors++; $display("FAIL bp_hold t%0d: got %b exp 00010", t, out_data); end
      end
      if (t == 2) begin
        vectors++; if (in_ready !== 1'b0) begin errors++; $display("FAIL bp_in_ready_full: got %b exp 0", in_ready); end
      end
    end
    vectors++;
    if (got_q.size() != 4) begin errors++; $display("FAIL bp_count: got %0d exp 4", got_q.size()); end
    else for (int i = 0; i < 4; i++) begin
      vectors++;
      if (got_q[i] !== exp_bp[i]) begin errors++; $display("FAIL bp_order[%0d]: got %b exp %b", i, got_q[i], exp_bp[i]); end
    end
  endtask

  task automatic test_reconfig();
    got_q.delete();
    step(1, 4'b0001, 0, 0);
    step(1, 4'b0010, 0, 0);
    step(0, '0, 0, 1);
    vectors++; if (state !== 2'd2) begin errors++; $display("FAIL reopen_drain: got %0d exp 2", state); end
    cfg_op(1, 2'd1, 5'b11111, 0);            // write during DRAIN: rejected
    drain_to_cfg();
    vectors++;
    if (got_q.size() != 2 || got_q[0] !== 5'b00010 || got_q[1] !== 5'b00101) begin
      errors++; $display("FAIL reopen_delivered: got %0d words", got_q.size());
    end
    cfg_op(1, 2'd1, 5'b11111, 1);
    step(1, 4'b0010, 1, 0);
    step(0, '0, 1, 0);
    vectors++; if (out_data !== 5'b11111) begin errors++; $display("FAIL reconfig_row1: got %b exp 11111", out_data); end
    step(0, '0, 1, 0);
  endtask

`ifdef BMF_XOR_SEMIRING_EN
  task automatic test_xor();
    drain_to_cfg();
    col_xor = 5'b00001;
    cfg_op(1, 2'd1, 5'b00101, 1);
    col_xor = '0;
    step(1, 4'b0110, 1, 0);
    step(1, 4'b1110, 1, 0);
    vectors++; if (out_data !== 5'b01100) begin errors++; $display("FAIL xor_0110: got %b exp 01100", out_data); end
    step(0, '0, 1, 0);
    vectors++; if (out_data !== 5'b11101) begin errors++; $display("FAIL xor_1110: got %b exp 11101", out_data); end
    step(0, '0, 1, 0);
  endtask
`endif

  task automatic test_random();
    for (int rnd = 0; rnd < 3; rnd++) begin
      drain_to_cfg();
`ifdef BMF_XOR_SEMIRING_EN
      col_xor = M'($urandom);
`endif
      for (int r = 0; r < K; r++) cfg_op(1, 2'(r), M'($urandom), (r == K - 1));
      for (int t = 0; t < 150; t++)
        step(1'($urandom_range(0, 1)), K'($urandom), ($urandom_range(0, 3) != 0), 0);
    end
  endtask

  task automatic test_wrap();
    int sent;
    do_reset();
    cfg_op(1, 2'd0, 5'b00010, 0);
    cfg_op(1, 2'd1, 5'b00101, 0);
    cfg_op(1, 2'd2, 5'b01001, 0);
    cfg_op(1, 2'd3, 5'b10001, 1);
    sent = 0;
    for (int t = 0; t < 60 && (sent < 17 || code_q.size() > 0); t++) begin
      step(sent < 17, K'($urandom), 1, 0);
      if (last_acc) sent++;
    end
    vectors++; if (res_count !== 4'd1) begin errors++; $display("FAIL wrap_count: got %0d exp 1", res_count); end
    step(1, 4'b0011, 0, 0);
    step(1, 4'b0101, 0, 0);
    do_reset();
    vectors++; if (out_valid !== 1'b0) begin errors++; $display("FAIL midrst_out_valid: got %b exp 0", out_valid); end
    vectors++; if (state !== 2'd0) begin errors++; $display("FAIL midrst_state: got %0d exp 0", state); end
    vectors++; if (res_count !== '0) begin errors++; $display("FAIL midrst_res_count: got %0d exp 0", res_count); end
    vectors++; if (in_ready !== 1'b0) begin errors++; $display("FAIL midrst_in_ready: got %b exp 0", in_ready); end
  endtask

  initial begin
    test_reset();
    test_config_check();
    test_or_decode();
    test_backpressure();
    test_reconfig();
`ifdef BMF_XOR_SEMIRING_EN
    test_xor();
`endif
    test_random();
    test_wrap();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
